// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial adder/subtractor with valid/ready operand and result handshakes
//
// One full-adder cell and a carry/borrow flop process the operands LSB first,
// one bit per clock. A result is presented exactly WIDTH cycles after the
// operands are accepted and is held until the consumer takes it.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair a/b/sub is valid
//   in_ready   block can accept operands (IDLE only)
//   a          minuend / augend
//   b          subtrahend / addend
//   sub        1 = a-b, 0 = a+b
//   out_valid  result, cb and ovf are valid (DONE only)
//   out_ready  consumer accepts the result
//   result     a-b or a+b modulo 2^WIDTH
//   cb         carry-out (add) or borrow-out (sub)
//   ovf        signed two's-complement overflow

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cb,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic            sub_r;
  logic            c_r;
  // Original operand MSBs; the shift registers have lost them by the last bit.
  logic            a_msb;
  logic            b_msb;

  logic a_i;
  logic b_i;
  logic p_i;
  logic sum_bit;
  logic c_next;
  logic ovf_next;

  assign a_i     = a_sr[0];
  assign b_i     = b_sr[0];
  assign p_i     = a_i ^ b_i;
  assign sum_bit = p_i ^ c_r;
  // Carry for add, borrow for subtract; the difference bit has the same form as the sum bit.
  assign c_next  = sub_r ? ((~a_i & b_i) | (c_r & ~p_i))
                         : ((a_i & b_i) | (c_r & p_i));
  // sum_bit is the result MSB when evaluated on the last bit.
  assign ovf_next = sub_r ? ((a_msb != b_msb) && (sum_bit != a_msb))
                          : ((a_msb == b_msb) && (sum_bit != a_msb));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      sub_r     <= 1'b0;
      c_r       <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      result    <= '0;
      cb        <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr     <= a;
            b_sr     <= b;
            sub_r    <= sub;
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
            c_r      <= 1'b0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          result <= {sum_bit, result[WIDTH-1:1]};
          c_r    <= c_next;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            cb        <= c_next;
            ovf       <= ovf_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor

module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       sub = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result;
  logic       cb;
  logic       ovf;

  logic       in_valid3 = 1'b0;
  logic       in_ready3;
  logic [2:0] a3 = '0;
  logic [2:0] b3 = '0;
  logic       sub3 = 1'b0;
  logic       out_valid3;
  logic       out_ready3 = 1'b0;
  logic [2:0] result3;
  logic       cb3;
  logic       ovf3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cb(cb), .ovf(ovf)
  );

  serial_subtractor #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .a(a3), .b(b3), .sub(sub3),
    .out_valid(out_valid3), .out_ready(out_ready3),
    .result(result3), .cb(cb3), .ovf(ovf3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Golden model from plain integer arithmetic: returns {cb, ovf, result} in bits [w+1:0].
  function automatic logic [31:0] model(input int w, input int x, input int y, input bit s);
    int  m, r, sx, sy, sr;
    bit  c, o;
    m  = 1 << w;
    r  = s ? x - y : x + y;
    c  = s ? (x < y) : (r >= m);
    sx = (x >= m / 2) ? x - m : x;
    sy = (y >= m / 2) ? y - m : y;
    sr = s ? sx - sy : sx + sy;
    o  = (sr < -(m / 2)) || (sr >= m / 2);
    r  = ((r % m) + m) % m;
    return (32'(c) << (w + 1)) | (32'(o) << w) | 32'(r);
  endfunction

  // One WIDTH=8 operation; junk in_valid pulses are injected while busy.
  task automatic run8(input logic [7:0] xa, input logic [7:0] xb, input bit s,
                      input int hold, input logic [9:0] exp);
    int lat;
    logic [10:0] snap;
    @(posedge clk); #1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    a = xa; b = xb; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_valid = 1'($urandom_range(0, 1));
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd8);
    chk("result", 32'(result), 32'(exp[7:0]));
    chk("ovf", 32'(ovf), 32'(exp[8]));
    chk("cb", 32'(cb), 32'(exp[9]));
    snap = {out_valid, cb, ovf, result};
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("hold", 32'({out_valid, cb, ovf, result}), 32'(snap));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_hs", 32'(out_valid), 32'd0);
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
    if (hold > 0) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        chk("no_second_result", 32'(out_valid), 32'd0);
      end
    end
  endtask

  task automatic run3(input int xa, input int xb, input bit s);
    int lat;
    logic [31:0] exp;
    exp = model(3, xa, xb, s);
    @(posedge clk); #1;
    a3 = 3'(xa); b3 = 3'(xb); sub3 = s; in_valid3 = 1'b1;
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    lat = 0;
    while (!out_valid3 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w3_latency", 32'(lat), 32'd3);
    chk("w3_result", 32'(result3), 32'(exp[2:0]));
    chk("w3_ovf", 32'(ovf3), 32'(exp[3]));
    chk("w3_cb", 32'(cb3), 32'(exp[4]));
    out_ready3 = 1'b1;
    @(posedge clk); #1;
    out_ready3 = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    bit rs;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cb", 32'(cb), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // Directed vectors with hand-derived results {cb, ovf, result}
    run8(8'h05, 8'h03, 1'b1, 0, 10'h002);
    run8(8'h03, 8'h05, 1'b1, 0, 10'h2FE);
    run8(8'h80, 8'h01, 1'b1, 0, 10'h17F);
    run8(8'hFF, 8'h01, 1'b0, 0, 10'h200);
    run8(8'h7F, 8'h01, 1'b0, 0, 10'h180);

    // Back-pressure for 5 cycles in DONE
    run8(8'h3C, 8'h5A, 1'b1, 5, 10'(model(8, 8'h3C, 8'h5A, 1'b1)));

    // Reset in the middle of RUN
    @(posedge clk); #1;
    a = 8'h55; b = 8'h22; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midrun_rst_result", 32'(result), 32'd0);
    chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("midrun_rst_no_result", 32'(out_valid), 32'd0);
    run8(8'h10, 8'h01, 1'b1, 0, 10'h00F);

    // Randomized operations against the integer model
    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      run8(ra, rb, rs, int'($urandom_range(0, 3)), 10'(model(8, int'(ra), int'(rb), rs)));
    end

    // Exhaustive WIDTH=3 sweep
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 8; x++)
        for (int y = 0; y < 8; y++)
          run3(x, y, 1'(s));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
